// File: rtl/hazard_ctl.sv
// Pipeline hazard controller: load-use stalls, taken-branch flushes and external hold,
// with saturating stall/flush event counters.
module hazard_ctl (
  input  logic       clk,
  input  logic       reset,
  input  logic [4:0] id_rs,
  input  logic [4:0] id_rt,
  input  logic       ex_memread,
  input  logic [4:0] ex_rt,
  input  logic       mem_branch,
  input  logic       mem_zero,
  input  logic       ext_hold,
  output logic       pc_write,
  output logic       ifid_write,
  output logic       idex_bubble,
  output logic       ifid_flush,
  output logic       idex_flush,
  output logic       exmem_flush,
  output logic [7:0] stall_cnt,
  output logic [7:0] flush_cnt,
  output logic [1:0] state
);

  typedef enum logic [1:0] {
    StRun   = 2'd0,
    StStall = 2'd1,
    StFlush = 2'd2,
    StHold  = 2'd3
  } state_e;

  state_e     state_q, state_d;
  logic [7:0] stall_cnt_q, flush_cnt_q;
  logic       stall_inc, flush_inc;
  logic       load_use, taken_branch;

  // Register $0 is never a real producer, so a load targeting it cannot create a hazard.
  assign load_use     = ex_memread && (ex_rt != 5'd0) && ((ex_rt == id_rs) || (ex_rt == id_rt));
  assign taken_branch = mem_branch && mem_zero;

  always_comb begin
    pc_write    = 1'b1;
    ifid_write  = 1'b1;
    idex_bubble = 1'b0;
    ifid_flush  = 1'b0;
    idex_flush  = 1'b0;
    exmem_flush = 1'b0;
    state_d     = StRun;
    stall_inc   = 1'b0;
    flush_inc   = 1'b0;
    if (!reset) begin
      pc_write    = 1'b0;
      ifid_write  = 1'b0;
      idex_bubble = 1'b1;
      ifid_flush  = 1'b1;
      idex_flush  = 1'b1;
      exmem_flush = 1'b1;
    end else if (taken_branch) begin
      ifid_write  = 1'b0;
      idex_bubble = 1'b1;
      ifid_flush  = 1'b1;
      idex_flush  = 1'b1;
      exmem_flush = 1'b1;
      state_d     = StFlush;
      flush_inc   = 1'b1;
    end else if (ext_hold) begin
      pc_write    = 1'b0;
      ifid_write  = 1'b0;
      idex_bubble = 1'b1;
      state_d     = StHold;
      stall_inc   = 1'b1;
    end else if (load_use && (state_q == StRun || state_q == StHold)) begin
      pc_write    = 1'b0;
      ifid_write  = 1'b0;
      idex_bubble = 1'b1;
      state_d     = StStall;
      stall_inc   = 1'b1;
    end
    // STALL and FLUSH fall through to the free-running defaults: their LU is stale.
  end

  always_ff @(posedge clk) begin
    if (!reset) begin
      state_q     <= StRun;
      stall_cnt_q <= 8'd0;
      flush_cnt_q <= 8'd0;
    end else begin
      state_q <= state_d;
      if (stall_inc && (stall_cnt_q != 8'hff)) stall_cnt_q <= stall_cnt_q + 8'd1;
      if (flush_inc && (flush_cnt_q != 8'hff)) flush_cnt_q <= flush_cnt_q + 8'd1;
    end
  end

  assign stall_cnt = stall_cnt_q;
  assign flush_cnt = flush_cnt_q;
  assign state     = state_q;

endmodule
